caliptra_fpga_sync_reg_arb: RTL and testbench
=============================================

CALIPTRA_FPGA_SYNC_REG_ARB -- requirements
Module: caliptra_fpga_sync_reg_arb

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters (fixed 2 for this revision).
REQ-002 aclk  input  1  sole clock; all logic rising-edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  [1:0]  per-requester transaction request, held until ack.
REQ-005 we  input  [1:0]  per-requester write(1)/read(0).
REQ-006 addr  input  [63:0]  two packed 32-bit byte addresses, requester i at [32i+31:32i].
REQ-007 wdata  input  [127:0]  two packed 64-bit write data words.
REQ-008 wstrb  input  [15:0]  two packed 8-bit byte strobes.
REQ-009 ack  output  [1:0]  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  64  read data, valid with ack.
REQ-011 err  output  1  slave response was not OKAY, valid with ack.
REQ-012 m_arvalid/m_araddr[31:0]/m_arprot[2:0]  output  AXI4-Lite read address to the register slave; m_arready input.
REQ-013 m_rready  output; m_rvalid, m_rdata[63:0], m_rresp[1:0]  input  read data channel.
REQ-014 m_awvalid/m_awaddr[31:0]/m_awprot[2:0]  output; m_awready input  write address channel.
REQ-015 m_wvalid/m_wdata[63:0]/m_wstrb[7:0]  output; m_wready input  write data channel.
REQ-016 m_bready  output; m_bvalid, m_bresp[1:0]  input  write response channel.

Function
REQ-017 The block SHALL serialise requests from two requesters onto one AXI4-Lite master port, one outstanding transaction at a time.
REQ-018 FSM states SHALL be IDLE, AR, R, AW_W, B, ACK.
REQ-019 IDLE: if any req bit set, grant one requester, latch its addr/wdata/wstrb/we, go to AR (read) or AW_W (write).
REQ-020 Arbitration SHALL be round-robin: on simultaneous req, the requester not granted last wins; after reset, requester 0 has priority.
REQ-021 AR: m_arvalid=1 with latched address until m_arready sampled high, then R.
REQ-022 R: m_rready=1 until m_rvalid sampled high; capture m_rdata and m_rresp; go to ACK.
REQ-023 AW_W: m_awvalid and m_wvalid asserted together; each deasserts independently on its own handshake; go to B once both handshakes have completed (same or different cycles).
REQ-024 B: m_bready=1 until m_bvalid sampled high; capture m_bresp; go to ACK.
REQ-025 ACK: ack[grant]=1 for exactly one cycle, rdata=captured data (zero for writes), err=(captured resp != 2'b00); next state IDLE.
REQ-026 req is not sampled in ACK; requesters SHALL deassert req on the edge at which they see ack, otherwise a new transaction is started from IDLE.
REQ-027 Zero-wait-state read latency SHALL be: req sampled in IDLE at edge 0, m_arvalid high cycle 1, R cycle 2, ack high cycle 3.
REQ-028 m_arprot and m_awprot SHALL be constant 3'b000.
REQ-029 AXI valid signals SHALL NOT depend combinationally on ready inputs; all outputs SHALL be registered.
REQ-030 Address/data/strobe outputs SHALL remain stable while the corresponding valid is high.
REQ-031 A req bit dropped before ack SHALL NOT abort an in-flight transaction; it completes, and ack is still issued.

Reset
REQ-032 On rstn low: state=IDLE, round-robin pointer to requester 0, ack=0, err=0, rdata=0, all m_*valid and m_*ready outputs 0, latched address/data/strobes 0.
REQ-033 Reset mid-transaction SHALL abandon it immediately with no ack; the slave is reset by the same rstn.

Structure
REQ-034 Shared package caliptra_fpga_sync_pkg SHALL hold the FSM state enum, the AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the address/data width constants (32/64).
REQ-035 The two-way round-robin grant logic SHALL be one sub-module, caliptra_fpga_sync_rr_arb (req in, grant out, update enable).

Verification
REQ-036 Single read, req=2'b01, addr0=0x10, slave ready immediately returning 0x1122334455667788/OKAY -> m_araddr=0x10, ack=2'b01 at cycle 3, rdata=0x1122334455667788, err=0.
REQ-037 Simultaneous write req=2'b11 after reset, wdata0=0xA, wdata1=0xB, wstrb=0xFF -> requester 0 served first (m_wdata=0xA), then requester 1 (0xB); two ack pulses, 2'b01 then 2'b10.
REQ-038 Write with m_awready delayed 3 cycles and m_wready immediate -> m_wvalid drops after 1 cycle, m_awvalid held 4 cycles with stable m_awaddr, m_bready only after both handshakes.
REQ-039 Read returning m_rresp=2'b10 -> ack pulse with err=1; next read returning OKAY -> err=0.
REQ-040 rstn asserted while in B state -> all outputs zero within the reset, no ack; after release, req=2'b10 is served with requester 1 granted.
REQ-041 Both requesters continuously re-requesting for 8 transactions -> grants alternate 0,1,0,1,... with no back-to-back grant to the same requester.

Source files
------------

// File: rtl/caliptra_fpga_sync_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
package caliptra_fpga_sync_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B,
        ACK
    } state_e;

    // Anything other than OKAY (EXOKAY and DECERR included) is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic is_err;
        unique case (resp)
            RESP_OKAY:   is_err = 1'b0;
            RESP_SLVERR: is_err = 1'b1;
            default:     is_err = 1'b1;
        endcase
        return is_err;
    endfunction

endpackage

// File: rtl/caliptra_fpga_sync_rr_arb.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module caliptra_fpga_sync_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

    // prio_q high means requester 1 wins the next tie.
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = prio_q ? 2'b10 : 2'b01;
        end
        prio_d = prio_q;
        if (update_i && (|req_i)) begin
            prio_d = grant_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/caliptra_fpga_sync_reg_arb.sv
// Serialises two register requesters onto one AXI4-Lite master, one transaction at a time.
module caliptra_fpga_sync_reg_arb
    import caliptra_fpga_sync_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                      aclk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    input  logic [N_REQ*STRB_W-1:0]   wstrb,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      m_arvalid,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [2:0]                m_arprot,
    input  logic                      m_arready,
    output logic                      m_rready,
    input  logic                      m_rvalid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_awvalid,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic [2:0]                m_awprot,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [STRB_W-1:0]         m_wstrb,
    input  logic                      m_wready,
    output logic                      m_bready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   arb_grant;
    logic               arb_update;
    logic               sel;
    logic               aw_done;
    logic               w_done;

    caliptra_fpga_sync_rr_arb u_rr_arb (
        .clk_i    (aclk),
        .rst_ni   (rstn),
        .req_i    (req),
        .update_i (arb_update),
        .grant_o  (arb_grant)
    );

    assign sel     = arb_grant[1];
    assign aw_done = !awvalid_q || m_awready;
    assign w_done  = !wvalid_q || m_wready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        arb_update = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    arb_update = 1'b1;
                    grant_d    = arb_grant;
                    addr_d     = sel ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
                    wdata_d    = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                    wstrb_d    = sel ? wstrb[2*STRB_W-1:STRB_W] : wstrb[STRB_W-1:0];
                    if (we[sel]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_rdata;
                    err_d    = resp_is_err(m_rresp);
                    ack_d    = grant_q;
                    state_d  = ACK;
                end
            end
            AW_W: begin
                // Address and data channels retire independently; B waits for both.
                if (awvalid_q && m_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    rdata_d  = '0;
                    err_d    = resp_is_err(m_bresp);
                    ack_d    = grant_q;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign m_arvalid = arvalid_q;
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_rready  = rready_q;
    assign m_awvalid = awvalid_q;
    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = bready_q;

endmodule

// File: tb/tb_caliptra_fpga_sync_reg_arb.sv
// Bench for the AXI4-Lite register arbiter: transaction-level model, AXI slave and directed tests.
module tb_caliptra_fpga_sync_reg_arb;

    logic         aclk = 1'b0;
    logic         rstn;
    logic [1:0]   req;
    logic [1:0]   we;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic [1:0]   ack;
    logic [63:0]  rdata;
    logic         err;
    logic         m_arvalid;
    logic [31:0]  m_araddr;
    logic [2:0]   m_arprot;
    logic         m_arready = 1'b0;
    logic         m_rready;
    logic         m_rvalid = 1'b0;
    logic [63:0]  m_rdata = 64'h0;
    logic [1:0]   m_rresp = 2'b00;
    logic         m_awvalid;
    logic [31:0]  m_awaddr;
    logic [2:0]   m_awprot;
    logic         m_awready = 1'b0;
    logic         m_wvalid;
    logic [63:0]  m_wdata;
    logic [7:0]   m_wstrb;
    logic         m_wready = 1'b0;
    logic         m_bready;
    logic         m_bvalid = 1'b0;
    logic [1:0]   m_bresp = 2'b00;

    int testsRun    = 0;
    int testsFailed = 0;

    // Slave behaviour knobs, set by the stimulus
    int          arDelay = 0;
    int          awDelay = 0;
    int          wDelay  = 0;
    int          rDelay  = 0;
    int          bDelay  = 0;
    logic [63:0] slaveRdata = 64'h0;
    logic [1:0]  slaveRresp = 2'b00;
    logic [1:0]  slaveBresp = 2'b00;

    caliptra_fpga_sync_reg_arb #(.N_REQ(2)) dut (
        .aclk      (aclk),
        .rstn      (rstn),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_arready (m_arready),
        .m_rready  (m_rready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_awvalid (m_awvalid),
        .m_awaddr  (m_awaddr),
        .m_awprot  (m_awprot),
        .m_awready (m_awready),
        .m_wvalid  (m_wvalid),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wready  (m_wready),
        .m_bready  (m_bready),
        .m_bvalid  (m_bvalid),
        .m_bresp   (m_bresp)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Transaction model: phase 0 = idle (req sampled), 1 = bus transfer, 2 = ack cycle
    int          phase     = 0;
    int          lastGrant = 1;
    int          mGrant    = 0;
    logic        mWe       = 1'b0;
    logic [31:0] mAddr     = 32'h0;
    logic [63:0] mWdata    = 64'h0;
    logic [7:0]  mWstrb    = 8'h0;
    logic [63:0] mRdata    = 64'h0;
    logic        mErr      = 1'b0;
    bit          startedNow = 1'b0;
    bit          awDoneM    = 1'b0;
    bit          wDoneM     = 1'b0;

    always @(posedge aclk) begin
        if (!rstn) begin
            phase      = 0;
            lastGrant  = 1;
            startedNow = 1'b0;
            awDoneM    = 1'b0;
            wDoneM     = 1'b0;
        end else begin
            startedNow = 1'b0;
            case (phase)
                2: phase = 0;
                0: begin
                    if (req != 2'b00) begin
                        if (req == 2'b11) mGrant = 1 - lastGrant;
                        else              mGrant = req[1] ? 1 : 0;
                        lastGrant  = mGrant;
                        mWe        = we[mGrant];
                        mAddr      = (mGrant == 1) ? addr[63:32]   : addr[31:0];
                        mWdata     = (mGrant == 1) ? wdata[127:64] : wdata[63:0];
                        mWstrb     = (mGrant == 1) ? wstrb[15:8]   : wstrb[7:0];
                        awDoneM    = 1'b0;
                        wDoneM     = 1'b0;
                        startedNow = 1'b1;
                        phase      = 1;
                    end
                end
                default: begin
                    if (m_awvalid && m_awready) awDoneM = 1'b1;
                    if (m_wvalid && m_wready)   wDoneM  = 1'b1;
                    if (!mWe && m_rvalid && m_rready) begin
                        mRdata = m_rdata;
                        mErr   = (m_rresp != 2'b00);
                        phase  = 2;
                    end
                    if (mWe && m_bvalid && m_bready) begin
                        mRdata = 64'h0;
                        mErr   = (m_bresp != 2'b00);
                        phase  = 2;
                    end
                end
            endcase
        end
    end

    // Compare process, sampled on the falling edge
    always @(negedge aclk) begin
        if (!rstn) begin
            checkOutput("resetAck", 64'(ack), 64'h0);
            checkOutput("resetRdataErr", 64'({err, rdata}), 64'h0);
            checkOutput("resetHandshakes", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'h0);
            checkOutput("resetLatched", 64'({m_araddr, m_wstrb}), 64'h0);
            checkOutput("resetWdata", m_wdata, 64'h0);
        end else begin
            checkOutput("ack", 64'(ack), (phase == 2) ? ((mGrant == 1) ? 64'h2 : 64'h1) : 64'h0);
            checkOutput("prot", 64'({m_arprot, m_awprot}), 64'h0);
            if (phase == 2) begin
                checkOutput("rdata", rdata, mRdata);
                checkOutput("err", 64'(err), 64'(mErr));
            end
            if (phase != 1) begin
                checkOutput("idleBus", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'h0);
            end else begin
                if (startedNow) begin
                    checkOutput("firstValids", 64'({m_arvalid, m_awvalid, m_wvalid}), mWe ? 64'h3 : 64'h4);
                end
                if (m_arvalid) begin
                    checkOutput("arAddr", 64'(m_araddr), 64'(mAddr));
                    checkOutput("arForRead", 64'(mWe), 64'h0);
                end
                if (m_awvalid) begin
                    checkOutput("awAddr", 64'(m_awaddr), 64'(mAddr));
                    checkOutput("awAfterHandshake", 64'(awDoneM), 64'h0);
                end
                if (m_wvalid) begin
                    checkOutput("wData", m_wdata, mWdata);
                    checkOutput("wStrb", 64'(m_wstrb), 64'(mWstrb));
                    checkOutput("wAfterHandshake", 64'(wDoneM), 64'h0);
                end
                if (m_bready) begin
                    checkOutput("bReadyAfterBoth", 64'({awDoneM, wDoneM}), 64'h3);
                end
            end
        end
    end

    // AXI4-Lite slave with programmable ready/valid latency
    int rCnt = 0, bCnt = 0, arCnt = 0, awCnt = 0, wCnt = 0;
    bit rPending = 1'b0, bPending = 1'b0, awSeen = 1'b0, wSeen = 1'b0;

    always @(posedge aclk) begin
        if (!rstn) begin
            rPending = 1'b0;
            bPending = 1'b0;
            awSeen   = 1'b0;
            wSeen    = 1'b0;
            rCnt = 0; bCnt = 0; arCnt = 0; awCnt = 0; wCnt = 0;
            #1;
            m_arready = 1'b0;
            m_awready = 1'b0;
            m_wready  = 1'b0;
            m_rvalid  = 1'b0;
            m_bvalid  = 1'b0;
        end else begin
            if (m_arvalid && m_arready) rPending = 1'b1;
            if (m_rvalid && m_rready)   rPending = 1'b0;
            if (m_awvalid && m_awready) awSeen   = 1'b1;
            if (m_wvalid && m_wready)   wSeen    = 1'b1;
            if (m_bvalid && m_bready)   bPending = 1'b0;
            if (awSeen && wSeen) begin
                bPending = 1'b1;
                awSeen   = 1'b0;
                wSeen    = 1'b0;
            end
            #1;
            if (m_arvalid) begin m_arready = (arCnt >= arDelay); arCnt++; end
            else begin m_arready = 1'b0; arCnt = 0; end
            if (m_awvalid) begin m_awready = (awCnt >= awDelay); awCnt++; end
            else begin m_awready = 1'b0; awCnt = 0; end
            if (m_wvalid) begin m_wready = (wCnt >= wDelay); wCnt++; end
            else begin m_wready = 1'b0; wCnt = 0; end
            if (rPending) begin
                m_rvalid = (rCnt >= rDelay);
                m_rdata  = slaveRdata;
                m_rresp  = slaveRresp;
                rCnt++;
            end else begin
                m_rvalid = 1'b0;
                rCnt     = 0;
            end
            if (bPending) begin
                m_bvalid = (bCnt >= bDelay);
                m_bresp  = slaveBresp;
                bCnt++;
            end else begin
                m_bvalid = 1'b0;
                bCnt     = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] weV,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [7:0] s0, input logic [7:0] s1);
        @(negedge aclk);
        #1;
        we    = weV;
        addr  = {a1, a0};
        wdata = {d1, d0};
        wstrb = {s1, s0};
        req   = reqV;
    endtask

    task automatic waitAck(input string name, input logic [1:0] expected, input logic [1:0] dropMask);
        logic [1:0] seen;
        seen = 2'b00;
        for (int i = 0; i < 64; i++) begin
            @(negedge aclk);
            if (ack != 2'b00) begin
                seen = ack;
                req  = req & ~(ack & dropMask);
                break;
            end
        end
        checkOutput(name, 64'(seen), 64'(expected));
    endtask

    task automatic pulseReset();
        @(negedge aclk);
        #1;
        rstn = 1'b0;
        req  = 2'b00;
        repeat (2) @(negedge aclk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int awCycles;
        int wCycles;
        int earlyB;
        logic [1:0] ackSeen;

        rstn  = 1'b0;
        req   = 2'b00;
        we    = 2'b00;
        addr  = 64'h0;
        wdata = 128'h0;
        wstrb = 16'h0;
        @(negedge aclk);
        checkOutput("litResetAck", 64'(ack), 64'h0);
        checkOutput("litResetRdata", rdata, 64'h0);
        repeat (2) @(negedge aclk);
        #1;
        rstn = 1'b1;
        repeat (2) @(negedge aclk);

        $display("[TB] single zero-wait read");
        slaveRdata = 64'h1122334455667788;
        slaveRresp = 2'b00;
        applyStimulus(2'b01, 2'b00, 32'h10, 32'h99, 64'h0, 64'h0, 8'h0, 8'h0);
        @(negedge aclk);
        checkOutput("litArValidCycle1", 64'(m_arvalid), 64'h1);
        checkOutput("litArAddr", 64'(m_araddr), 64'h10);
        @(negedge aclk);
        checkOutput("litRReadyCycle2", 64'(m_rready), 64'h1);
        @(negedge aclk);
        checkOutput("litAckCycle3", 64'(ack), 64'h1);
        checkOutput("litRdata", rdata, 64'h1122334455667788);
        checkOutput("litErrOkay", 64'(err), 64'h0);
        req = 2'b00;
        repeat (2) @(negedge aclk);

        $display("[TB] simultaneous writes after reset");
        pulseReset();
        applyStimulus(2'b11, 2'b11, 32'h20, 32'h24, 64'hA, 64'hB, 8'hFF, 8'hFF);
        @(negedge aclk);
        checkOutput("litFirstWdata", m_wdata, 64'hA);
        waitAck("litAckReq0First", 2'b01, 2'b11);
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (m_wvalid) break;
        end
        checkOutput("litSecondWvalid", 64'(m_wvalid), 64'h1);
        checkOutput("litSecondWdata", m_wdata, 64'hB);
        waitAck("litAckReq1Second", 2'b10, 2'b11);

        $display("[TB] write with delayed awready");
        awDelay = 3;
        applyStimulus(2'b01, 2'b01, 32'h30, 32'h34, 64'h55, 64'h66, 8'h0F, 8'hF0);
        awCycles = 0;
        wCycles  = 0;
        earlyB   = 0;
        ackSeen  = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (m_awvalid) begin
                awCycles++;
                checkOutput("litAwAddrStable", 64'(m_awaddr), 64'h30);
            end
            if (m_wvalid) wCycles++;
            if (m_bready && (awCycles < 4)) earlyB++;
            if (ack != 2'b00) begin
                ackSeen = ack;
                break;
            end
        end
        req = 2'b00;
        checkOutput("litAwValidCycles", 64'(awCycles), 64'd4);
        checkOutput("litWValidCycles", 64'(wCycles), 64'd1);
        checkOutput("litNoEarlyBReady", 64'(earlyB), 64'd0);
        checkOutput("litDelayedWriteAck", 64'(ackSeen), 64'h1);
        awDelay = 0;

        $display("[TB] error response then okay");
        slaveRdata = 64'hDEAD;
        slaveRresp = 2'b10;
        applyStimulus(2'b10, 2'b00, 32'h40, 32'h44, 64'h0, 64'h0, 8'h0, 8'h0);
        waitAck("litAckSlvErr", 2'b10, 2'b11);
        checkOutput("litErrSet", 64'(err), 64'h1);
        slaveRresp = 2'b00;
        slaveRdata = 64'hCAFEF00D12345678;
        rDelay     = 2;
        applyStimulus(2'b10, 2'b00, 32'h40, 32'h48, 64'h0, 64'h0, 8'h0, 8'h0);
        waitAck("litAckOkay", 2'b10, 2'b11);
        checkOutput("litErrClear", 64'(err), 64'h0);
        checkOutput("litRdataDelayed", rdata, 64'hCAFEF00D12345678);
        rDelay = 0;

        $display("[TB] reset during write response");
        bDelay = 6;
        applyStimulus(2'b01, 2'b01, 32'h50, 32'h54, 64'h77, 64'h88, 8'hFF, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (m_bready) break;
        end
        checkOutput("litReachedB", 64'(m_bready), 64'h1);
        #1;
        rstn = 1'b0;
        req  = 2'b00;
        @(negedge aclk);
        checkOutput("litResetInBAck", 64'(ack), 64'h0);
        checkOutput("litResetInBReady", 64'({m_bready, m_awvalid, m_wvalid}), 64'h0);
        repeat (2) @(negedge aclk);
        #1;
        rstn   = 1'b1;
        bDelay = 0;
        slaveRdata = 64'h0123456789ABCDEF;
        applyStimulus(2'b10, 2'b00, 32'h50, 32'h60, 64'h0, 64'h0, 8'h0, 8'h0);
        @(negedge aclk);
        checkOutput("litArAddrAfterReset", 64'(m_araddr), 64'h60);
        waitAck("litAckReq1AfterReset", 2'b10, 2'b11);

        $display("[TB] req dropped mid-transaction");
        rDelay = 3;
        applyStimulus(2'b01, 2'b00, 32'h70, 32'h74, 64'h0, 64'h0, 8'h0, 8'h0);
        @(negedge aclk);
        #1;
        req = 2'b00;
        waitAck("litAckAfterDrop", 2'b01, 2'b00);
        rDelay = 0;

        $display("[TB] continuous requests from both");
        pulseReset();
        slaveRdata = 64'h5A5A5A5AA5A5A5A5;
        applyStimulus(2'b11, 2'b00, 32'h80, 32'h84, 64'h0, 64'h0, 8'h0, 8'h0);
        for (int i = 0; i < 8; i++) begin
            waitAck("litAlternatingGrant", (i % 2 == 0) ? 2'b01 : 2'b10, (i == 7) ? 2'b11 : 2'b00);
        end

        repeat (5) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
